sobel_adaptive_binarize: RTL
============================

Name: sobel_adaptive_binarize

Overview:
- Consumes the 8-bit Sobel magnitude stream (vs/de/data_en/data) and emits a binary edge map: 255 where magnitude > threshold, else 0.
- Threshold is adaptive: mean magnitude of the previous frame times a fixed gain, clamped to [TH_MIN, TH_MAX]. A manual override input bypasses the adaptation.
- Also reports per-frame edge-pixel count and the active threshold.
- Sits directly downstream of the Sobel stage and feeds the morphology/overlay path.

Parameters:
- COL, 640, active pixels per line.
- ROW, 480, active lines per frame.
- RECIP, 13981, round(2^32/(COL*ROW)); reciprocal used to form the mean.
- GAIN_Q3, 12, threshold gain in Q3 (12 = 1.5x).
- TH_MIN, 20, lower clamp of the adaptive threshold.
- TH_MAX, 200, upper clamp of the adaptive threshold.
- TH_INIT, 64, threshold value after reset.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  reset, synchronous, active-low; clock clk.
- s_vs  in  1  frame sync; rising edge = frame start.
- s_de  in  1  line-active qualifier.
- s_data_en  in  1  pixel-valid strobe.
- s_data  in  8  Sobel magnitude.
- manual_en  in  1  1 = use manual_th instead of the adaptive value.
- manual_th  in  8  manual threshold.
- bin_vs  out  1  s_vs delayed 1 cycle.
- bin_de  out  1  s_de delayed 1 cycle.
- bin_data_en  out  1  s_data_en delayed 1 cycle.
- bin_data  out  8  0 or 255.
- threshold  out  8  threshold currently applied.
- edge_count  out  20  edges counted in the last completed frame.
- frame_done  out  1  1-cycle pulse when edge_count and threshold have updated.

Behaviour:
- Reset:
  - All outputs 0, except threshold = TH_INIT.
  - Accumulators 0; FSM in IDLE.
- Pixel path (latency 1 cycle):
  - bin_data <= (s_de && s_data_en && s_data > th_eff) ? 255 : 0.
  - bin_vs, bin_de, bin_data_en are single-register copies of their inputs.
  - th_eff = manual_en ? manual_th : threshold. manual_en is sampled per cycle.
- Accumulation, on every cycle with s_de && s_data_en:
  - sum += s_data (32-bit; saturates at all-ones, never wraps).
  - If the pixel is an edge, cnt += 1 (20-bit, saturating).
- Frame boundary:
  - A vs rising edge (s_vs registered once, rise = s_vs & ~s_vs_d) latches sum→sum_l and cnt→cnt_l.
  - In the same cycle, sum and cnt clear to 0. A valid pixel arriving in that cycle counts into the new frame (accumulators load with it).
- FSM, one state per cycle:
  - IDLE: on vs rise → MEAN.
  - MEAN: mean = (sum_l*RECIP)>>32, clamped to 255 → SCALE.
  - SCALE: raw = (mean*GAIN_Q3)>>3, 11-bit → CLAMP.
  - CLAMP: th_new = min(max(raw, TH_MIN), TH_MAX) → UPDATE.
  - UPDATE: threshold <= th_new; edge_count <= cnt_l; frame_done = 1 → IDLE.
  - frame_done is asserted 5 cycles after the rising edge of s_vs.
  - Pixels arriving before UPDATE use the old threshold.
  - A vs rise while not in IDLE restarts at MEAN with newly latched values. The old computation is abandoned; no frame_done for it.
- First frame after reset has no valid predecessor: the UPDATE for the first vs rise is skipped (no threshold change, no frame_done). A first_frame flag is cleared by that vs rise.
- manual_en affects neither accumulation nor the FSM. threshold still tracks the adaptive value.
- Reset mid-frame returns everything to reset values immediately.

Decomposition:
- Shared package vip_pkg:
  - BIN_ON=255, BIN_OFF=0.
  - Q3 gain width (8).
  - FSM state enum (IDLE, MEAN, SCALE, CLAMP, UPDATE).
- One natural sub-module, frame_stat_acc: sum/count accumulators with saturation plus the vs-rise latch. The pixel compare and FSM stay in the top module.

Test Plan (COL=8, ROW=4, RECIP=2^27, GAIN_Q3=12, TH_MIN=20, TH_MAX=200, TH_INIT=64):
- After reset, frame of 32 pixels of value 100 → bin_data=255 each cycle one clock later. At the next vs rise there is no frame_done (first frame); threshold stays 64.
- Second frame of all 100, then vs rise → frame_done 5 cycles after the rise; mean=100, threshold=150, edge_count=32.
- Third frame: 16 pixels at 160 and 16 at 140 (threshold 150) → 16 outputs of 255. On the next vs rise: edge_count=16, mean=150, threshold=200 (raw 225 clamped).
- Frame of all 5 → threshold clamps to TH_MIN=20 on the following vs rise. manual_en=1 with manual_th=4 → all 5-valued pixels output 255, and threshold still reads 20.
- Second vs rise injected 2 cycles after the first → exactly one frame_done, 5 cycles after the second rise, with the second frame's statistics.
- rst_n low mid-frame for 1 cycle → all outputs 0, threshold=64; the next vs rise is treated as first-frame (no frame_done).

Source files
------------

// File: rtl/vip_pkg.sv
// Shared types and constants for the video binarization path.
package vip_pkg;

    localparam int unsigned PIX_W  = 8;
    localparam int unsigned GAIN_W = 8;

    localparam logic [PIX_W-1:0] BIN_ON  = 8'd255;
    localparam logic [PIX_W-1:0] BIN_OFF = 8'd0;

    typedef enum logic [2:0] {
        IDLE,
        MEAN,
        SCALE,
        CLAMP,
        UPDATE
    } bin_state_e;

endpackage

// File: rtl/frame_stat_acc.sv
// Per-frame saturating magnitude sum and edge count, latched on each vs rise.
module frame_stat_acc
    import vip_pkg::*;
#(
    parameter int unsigned SUM_W = 32,
    parameter int unsigned CNT_W = 20
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vs_rise,
    input  logic             pix_valid,
    input  logic             is_edge,
    input  logic [PIX_W-1:0] pix,
    output logic [SUM_W-1:0] sum_l,
    output logic [CNT_W-1:0] cnt_l
);

    logic [SUM_W-1:0] sum;
    logic [CNT_W-1:0] cnt;
    logic [SUM_W-1:0] sum_base;
    logic [CNT_W-1:0] cnt_base;
    logic [SUM_W:0]   sum_add;
    logic [SUM_W-1:0] sum_next;
    logic [CNT_W-1:0] cnt_next;

    // A pixel coinciding with a vs rise starts the new frame's totals.
    always_comb begin
        sum_base = vs_rise ? '0 : sum;
        cnt_base = vs_rise ? '0 : cnt;
        sum_add  = {1'b0, sum_base} + (SUM_W+1)'(pix);
        sum_next = sum_add[SUM_W] ? '1 : sum_add[SUM_W-1:0];
        cnt_next = cnt_base;
        if (is_edge && (cnt_base != '1)) begin
            cnt_next = cnt_base + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sum   <= '0;
            cnt   <= '0;
            sum_l <= '0;
            cnt_l <= '0;
        end else begin
            if (vs_rise) begin
                sum_l <= sum;
                cnt_l <= cnt;
            end
            if (pix_valid) begin
                sum <= sum_next;
                cnt <= cnt_next;
            end else if (vs_rise) begin
                sum <= '0;
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/sobel_adaptive_binarize.sv
// Binarizes a Sobel magnitude stream against a threshold adapted from the previous frame's mean.
module sobel_adaptive_binarize
    import vip_pkg::*;
#(
    parameter int unsigned COL     = 640,
    parameter int unsigned ROW     = 480,
    parameter int unsigned RECIP   = 32'(((64'd1 << 32) + 64'((COL * ROW) / 2)) / 64'(COL * ROW)),
    parameter int unsigned GAIN_Q3 = 12,
    parameter int unsigned TH_MIN  = 20,
    parameter int unsigned TH_MAX  = 200,
    parameter int unsigned TH_INIT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_vs,
    input  logic             s_de,
    input  logic             s_data_en,
    input  logic [PIX_W-1:0] s_data,
    input  logic             manual_en,
    input  logic [PIX_W-1:0] manual_th,
    output logic             bin_vs,
    output logic             bin_de,
    output logic             bin_data_en,
    output logic [PIX_W-1:0] bin_data,
    output logic [PIX_W-1:0] threshold,
    output logic [19:0]      edge_count,
    output logic             frame_done
);

    localparam int unsigned SUM_W = 32;
    localparam int unsigned CNT_W = 20;
    localparam int unsigned RAW_W = 11;

    bin_state_e         state;
    logic               s_vs_d;
    logic               first_frame;
    logic [PIX_W-1:0]   mean;
    logic [RAW_W-1:0]   raw;
    logic [PIX_W-1:0]   th_new;

    logic               vs_rise;
    logic               pix_valid;
    logic               is_edge;
    logic [PIX_W-1:0]   th_eff;
    logic [SUM_W-1:0]   sum_l;
    logic [CNT_W-1:0]   cnt_l;
    logic [31:0]        mean_full;
    logic [RAW_W-1:0]   raw_next;
    logic [PIX_W-1:0]   th_clamp;

    assign vs_rise   = s_vs & ~s_vs_d;
    assign pix_valid = s_de & s_data_en;
    assign th_eff    = manual_en ? manual_th : threshold;
    // Edge counting follows the adaptive threshold so manual mode never perturbs statistics.
    assign is_edge   = s_data > threshold;

    assign mean_full = 32'((64'(sum_l) * 64'(RECIP)) >> 32);
    assign raw_next  = RAW_W'(((GAIN_W * 2)'(mean) * (GAIN_W * 2)'(GAIN_Q3)) >> 3);
    assign th_clamp  = (raw < RAW_W'(TH_MIN)) ? PIX_W'(TH_MIN) :
                       (raw > RAW_W'(TH_MAX)) ? PIX_W'(TH_MAX) : raw[PIX_W-1:0];

    frame_stat_acc #(
        .SUM_W (SUM_W),
        .CNT_W (CNT_W)
    ) u_acc (
        .clk       (clk),
        .rst_n     (rst_n),
        .vs_rise   (vs_rise),
        .pix_valid (pix_valid),
        .is_edge   (is_edge),
        .pix       (s_data),
        .sum_l     (sum_l),
        .cnt_l     (cnt_l)
    );

    // Pixel path plus the one-state-per-cycle threshold update sequence.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_vs_d      <= 1'b0;
            bin_vs      <= 1'b0;
            bin_de      <= 1'b0;
            bin_data_en <= 1'b0;
            bin_data    <= BIN_OFF;
            threshold   <= PIX_W'(TH_INIT);
            edge_count  <= '0;
            frame_done  <= 1'b0;
            state       <= IDLE;
            first_frame <= 1'b1;
            mean        <= '0;
            raw         <= '0;
            th_new      <= '0;
        end else begin
            s_vs_d      <= s_vs;
            bin_vs      <= s_vs;
            bin_de      <= s_de;
            bin_data_en <= s_data_en;
            bin_data    <= (pix_valid && (s_data > th_eff)) ? BIN_ON : BIN_OFF;
            frame_done  <= 1'b0;
            if (vs_rise) begin
                // The frame before the first rise after reset is partial; skip its update.
                first_frame <= 1'b0;
                state       <= first_frame ? IDLE : MEAN;
            end else begin
                case (state)
                    IDLE: state <= IDLE;
                    MEAN: begin
                        mean  <= (mean_full > 32'd255) ? 8'd255 : mean_full[PIX_W-1:0];
                        state <= SCALE;
                    end
                    SCALE: begin
                        raw   <= raw_next;
                        state <= CLAMP;
                    end
                    CLAMP: begin
                        th_new <= th_clamp;
                        state  <= UPDATE;
                    end
                    UPDATE: begin
                        threshold  <= th_new;
                        edge_count <= cnt_l;
                        frame_done <= 1'b1;
                        state      <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
